// File: rtl/mux_arb.sv
// rtl/mux_arb.sv - one-entry registered N:1 mux with valid/ready handshake, external-select or round-robin grant
module mux_arb #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int MODE  = 0,
  parameter int SELW  = 2
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic [N*WIDTH-1:0] In,
  input  logic [N-1:0]       InValid,
  output logic [N-1:0]       InReady,
  input  logic [SELW-1:0]    Select,
  output logic [WIDTH-1:0]   Out,
  output logic               OutValid,
  input  logic               OutReady,
  output logic [SELW-1:0]    OutChan
);

  logic [SELW-1:0]  ptr;
  logic [SELW-1:0]  grant;
  logic             grant_vld;
  logic             free;
  logic             in_xfer;
  logic [WIDTH-1:0] grant_data;

  assign free = !OutValid || OutReady;

  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    if (MODE == 0) begin
      if (32'(Select) < 32'(N)) begin
        grant_vld = 1'b1;
        grant     = Select;
      end
    end else begin
      // Scan from the pointer upward, wrapping; the first valid channel wins.
      for (int k = 0; k < N; k++) begin
        int pos;
        pos = 32'(ptr) + k;
        if (pos >= N) pos = pos - N;
        for (int i = 0; i < N; i++) begin
          if (!grant_vld && i == pos && InValid[i]) begin
            grant_vld = 1'b1;
            grant     = SELW'(i);
          end
        end
      end
    end
  end

  always_comb begin
    InReady    = '0;
    grant_data = '0;
    for (int i = 0; i < N; i++) begin
      InReady[i] = grant_vld && free && (grant == SELW'(i));
      if (grant == SELW'(i)) grant_data = In[i*WIDTH +: WIDTH];
    end
  end

  assign in_xfer = |(InReady & InValid);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Out      <= '0;
      OutChan  <= '0;
      OutValid <= 1'b0;
      ptr      <= '0;
    end else begin
      if (in_xfer) begin
        Out      <= grant_data;
        OutChan  <= grant;
        OutValid <= 1'b1;
        if (MODE != 0) ptr <= (grant == SELW'(N-1)) ? '0 : grant + 1'b1;
      end else if (OutValid && OutReady) begin
        OutValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_arb.sv
// tb/tb_mux_arb.sv - self-checking bench for mux_arb in select mode and round-robin mode
module tb_mux_arb;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] in0, in1;
  logic [3:0]   in_valid0, in_valid1, in_ready0, in_ready1;
  logic [2:0]   sel0, out_chan0;
  logic [1:0]   sel1, out_chan1;
  logic [31:0]  out0, out1;
  logic         out_valid0, out_valid1, out_ready0, out_ready1;

  mux_arb #(.WIDTH(32), .N(4), .MODE(0), .SELW(3)) u_sel (
    .Clk(clk), .Rst_n(rst_n), .In(in0), .InValid(in_valid0), .InReady(in_ready0),
    .Select(sel0), .Out(out0), .OutValid(out_valid0), .OutReady(out_ready0), .OutChan(out_chan0)
  );

  mux_arb #(.WIDTH(32), .N(4), .MODE(1), .SELW(2)) u_rr (
    .Clk(clk), .Rst_n(rst_n), .In(in1), .InValid(in_valid1), .InReady(in_ready1),
    .Select(sel1), .Out(out1), .OutValid(out_valid1), .OutReady(out_ready1), .OutChan(out_chan1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic        m0_v = 1'b0;
  logic        m1_v = 1'b0;
  logic [1:0]  m1_p = 2'd0;
  logic [34:0] q0[$];
  logic [34:0] q1[$];
  int          log1[$];

  typedef struct {
    logic [2:0] sel;
    logic [3:0] vld;
    logic [3:0] rdy;
  } vec_t;

  vec_t tbl[8];
  int   exp_seq[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] lane(input logic [127:0] v, input int i);
    return v[i*32 +: 32];
  endfunction

  function automatic logic [127:0] pack4(input logic [31:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  // One clock of stimulus: predict ready/valid from the model at the falling edge,
  // score output transfers, then advance the model across the rising edge.
  task automatic cycle();
    logic [3:0]  er0, er1;
    logic        ix0, ix1, ox0, ox1;
    logic [34:0] e;
    int          g, p;
    @(negedge clk);
    er0 = '0;
    if (sel0 < 3'd4 && (!m0_v || out_ready0)) er0[sel0[1:0]] = 1'b1;
    chk("sel_in_ready", 64'(in_ready0), 64'(er0));
    chk("sel_out_valid", 64'(out_valid0), 64'(m0_v));
    ix0 = |(er0 & in_valid0);
    ox0 = m0_v && out_ready0;
    if (ox0) begin
      if (q0.size() == 0) begin
        checks++; failures++;
        $display("FAIL sel_unexpected_out actual=%0h expected=none", out0);
      end else begin
        e = q0.pop_front();
        chk("sel_out", 64'(out0), 64'(e[31:0]));
        chk("sel_out_chan", 64'(out_chan0), 64'(e[34:32]));
      end
    end
    if (ix0) q0.push_back({sel0, lane(in0, int'(sel0))});

    er1 = '0;
    g = -1;
    if (!m1_v || out_ready1)
      for (int k = 0; k < 4; k++) begin
        p = (int'(m1_p) + k) % 4;
        if (g < 0 && in_valid1[p]) g = p;
      end
    if (g >= 0) er1[g] = 1'b1;
    chk("rr_in_ready", 64'(in_ready1), 64'(er1));
    chk("rr_out_valid", 64'(out_valid1), 64'(m1_v));
    ix1 = (g >= 0);
    ox1 = m1_v && out_ready1;
    if (ox1) begin
      log1.push_back(int'(out_chan1));
      if (q1.size() == 0) begin
        checks++; failures++;
        $display("FAIL rr_unexpected_out actual=%0h expected=none", out1);
      end else begin
        e = q1.pop_front();
        chk("rr_out", 64'(out1), 64'(e[31:0]));
        chk("rr_out_chan", 64'(out_chan1), 64'(e[33:32]));
      end
    end
    if (ix1) q1.push_back({1'b0, 2'(g), lane(in1, g)});

    @(posedge clk);
    m0_v = ix0 | (m0_v & ~ox0);
    m1_v = ix1 | (m1_v & ~ox1);
    if (ix1) m1_p = 2'((g + 1) % 4);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{3'd1, 4'b0110, 4'b0010};
    tbl[1] = '{3'd2, 4'b0110, 4'b0100};
    tbl[2] = '{3'd0, 4'b0000, 4'b0001};
    tbl[3] = '{3'd3, 4'b1000, 4'b1000};
    tbl[4] = '{3'd5, 4'b1111, 4'b0000};
    tbl[5] = '{3'd7, 4'b1111, 4'b0000};
    tbl[6] = '{3'd4, 4'b1111, 4'b0000};
    tbl[7] = '{3'd0, 4'b1111, 4'b0001};
    exp_seq = '{0, 1, 2, 3, 0, 1};

    in0 = '0; in1 = '0; in_valid0 = '0; in_valid1 = '0;
    sel0 = '0; sel1 = '0; out_ready0 = 1'b0; out_ready1 = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_sel_out_valid", 64'(out_valid0), 64'd0);
    chk("rst_sel_out", 64'(out0), 64'd0);
    chk("rst_sel_out_chan", 64'(out_chan0), 64'd0);
    chk("rst_sel_in_ready", 64'(in_ready0), 64'b0001);
    chk("rst_rr_out_valid", 64'(out_valid1), 64'd0);
    chk("rst_rr_out", 64'(out1), 64'd0);
    chk("rst_rr_in_ready", 64'(in_ready1), 64'd0);
    rst_n = 1'b1;

    in0 = pack4(32'd7, 32'd50, 32'd10, 32'd99);
    out_ready0 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sel0 = tbl[i].sel;
      in_valid0 = tbl[i].vld;
      #1;
      chk("tbl_in_ready", 64'(in_ready0), 64'(tbl[i].rdy));
      cycle();
      if (i == 0) begin
        chk("first_out", 64'(out0), 64'd50);
        chk("first_chan", 64'(out_chan0), 64'd1);
        chk("first_valid", 64'(out_valid0), 64'd1);
      end
    end

    sel0 = 3'd5;
    in_valid0 = 4'b1111;
    cycle();
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("bad_sel_ready", 64'(in_ready0), 64'd0);
      chk("bad_sel_valid", 64'(out_valid0), 64'd0);
    end

    sel0 = 3'd1;
    in0 = pack4(32'd0, 32'hDEADBEEF, 32'd0, 32'd0);
    in_valid0 = 4'b0010;
    out_ready0 = 1'b0;
    cycle();
    in0 = pack4(32'd0, 32'h12345678, 32'd0, 32'd0);
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("bp_out_hold", 64'(out0), 64'hDEADBEEF);
      chk("bp_in_ready", 64'(in_ready0), 64'd0);
    end
    out_ready0 = 1'b1;
    cycle();
    chk("bp_next_word", 64'(out0), 64'h12345678);
    chk("bp_next_valid", 64'(out_valid0), 64'd1);
    in_valid0 = 4'b0000;
    cycle();

    log1.delete();
    in_valid1 = 4'b1111;
    out_ready1 = 1'b1;
    for (int c = 0; c < 8; c++) begin
      in1 = pack4(32'h100 + c, 32'h200 + c, 32'h300 + c, 32'h400 + c);
      sel1 = 2'($urandom);
      cycle();
    end
    in_valid1 = 4'b0000;
    cycle();
    chk("rr_seq_len", 64'(log1.size()), 64'd8);
    for (int k = 0; k < 6; k++)
      chk("rr_seq", (k < log1.size()) ? 64'(log1[k]) : 64'hFFFF, 64'(exp_seq[k]));

    log1.delete();
    in_valid1 = 4'b1001;
    repeat (3) cycle();
    in_valid1 = 4'b0000;
    cycle();
    chk("wrap_len", 64'(log1.size()), 64'd3);
    chk("wrap_0", (log1.size() > 0) ? 64'(log1[0]) : 64'hFFFF, 64'd0);
    chk("wrap_1", (log1.size() > 1) ? 64'(log1[1]) : 64'hFFFF, 64'd3);
    chk("wrap_2", (log1.size() > 2) ? 64'(log1[2]) : 64'hFFFF, 64'd0);

    for (int c = 0; c < 60; c++) begin
      sel0 = 3'($urandom_range(0, 7));
      in_valid0 = 4'($urandom);
      out_ready0 = ($urandom_range(0, 3) != 0);
      in0 = {$urandom, $urandom, $urandom, $urandom};
      sel1 = 2'($urandom);
      in_valid1 = 4'($urandom);
      out_ready1 = ($urandom_range(0, 3) != 0);
      in1 = {$urandom, $urandom, $urandom, $urandom};
      cycle();
    end

    in_valid0 = 4'b0000;
    out_ready0 = 1'b1;
    in_valid1 = 4'b1111;
    out_ready1 = 1'b1;
    repeat (3) cycle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid1), 64'd0);
    chk("mid_rst_out", 64'(out1), 64'd0);
    chk("mid_rst_chan", 64'(out_chan1), 64'd0);
    chk("mid_rst_sel_valid", 64'(out_valid0), 64'd0);
    m0_v = 1'b0; m1_v = 1'b0; m1_p = 2'd0;
    q0.delete(); q1.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    log1.delete();
    repeat (2) cycle();
    chk("resume_first_chan", (log1.size() > 0) ? 64'(log1[0]) : 64'hFFFF, 64'd0);

    in_valid1 = 4'b0000;
    repeat (3) cycle();
    chk("sel_queue_empty", 64'(q0.size()), 64'd0);
    chk("rr_queue_empty", 64'(q1.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
